// File: rtl/pc_sequencer_if.sv
// Bus between decode/fetch and the PC sequencer.
// Decode drives the operation fields. Fetch and status logic read the PC and stack state.
interface pc_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic             cond;
  logic [WIDTH-1:0] pc;
  logic [DW-1:0]    depth;
  logic             stack_full;
  logic             stack_empty;
  logic             fault;

  // Decode/fetch side
  modport master (
    output en, op, target, cond,
    input  pc, depth, stack_full, stack_empty, fault
  );

  // Sequencer side
  modport slave (
    input  en, op, target, cond,
    output pc, depth, stack_full, stack_empty, fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a small hardware return-address stack.
// It supports sequential fetch, conditional relative branches, absolute jumps and call/return.
// All arithmetic wraps modulo 2^WIDTH.
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | normal sequencing; en=1 applies op, en=0 stalls
// FAULT | stack over/underflow seen; everything frozen until rst
module pc_sequencer #(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_sequencer_if.slave        bus
);

  localparam int DW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] OP_NEXT    = 3'd0;
  localparam logic [2:0] OP_BR_FWD  = 3'd1;
  localparam logic [2:0] OP_BR_BACK = 3'd2;
  localparam logic [2:0] OP_JUMP    = 3'd3;
  localparam logic [2:0] OP_CALL    = 3'd4;
  localparam logic [2:0] OP_RET     = 3'd5;

  localparam logic [WIDTH-1:0] ONE_PC    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    ONE_D     = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_pc;
  logic [DW-1:0]    r_depth;
  logic             r_full;
  logic             r_empty;
  logic             r_fault;
  logic [WIDTH-1:0] r_stack [DEPTH];

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_pc_fwd;
  logic [WIDTH-1:0] w_pc_back;
  logic [DW-1:0]    w_depth_inc;
  logic [DW-1:0]    w_depth_dec;
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_top_idx;

  // Next-PC candidates and stack pointers, all wrap-around
  always_comb begin
    w_pc_inc    = r_pc + ONE_PC;
    w_pc_fwd    = r_pc + bus.target;
    w_pc_back   = r_pc - bus.target;
    w_depth_inc = r_depth + ONE_D;
    w_depth_dec = r_depth - ONE_D;
    w_push_idx  = r_depth[AW-1:0];
    w_top_idx   = w_depth_dec[AW-1:0];
  end

  // Sequencer FSM; all outputs registered, stack contents are not reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_depth <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.en) begin
            case (bus.op)
              OP_NEXT:    r_pc <= w_pc_inc;
              OP_BR_FWD:  r_pc <= bus.cond ? w_pc_fwd  : w_pc_inc;
              OP_BR_BACK: r_pc <= bus.cond ? w_pc_back : w_pc_inc;
              OP_JUMP:    r_pc <= bus.target;
              OP_CALL: begin
                if (r_full) begin
                  // Overflow freezes the PC at the offending call
                  r_fault <= 1'b1;
                  r_state <= ST_FAULT;
                end else begin
                  r_stack[w_push_idx] <= w_pc_inc;
                  r_pc    <= bus.target;
                  r_depth <= w_depth_inc;
                  r_full  <= (w_depth_inc == DEPTH_MAX);
                  r_empty <= 1'b0;
                end
              end
              OP_RET: begin
                if (r_empty) begin
                  r_fault <= 1'b1;
                  r_state <= ST_FAULT;
                end else begin
                  r_pc    <= r_stack[w_top_idx];
                  r_depth <= w_depth_dec;
                  r_full  <= 1'b0;
                  r_empty <= (w_depth_dec == '0);
                end
              end
              default: ;  // ops 6/7 hold
            endcase
          end
        end
        ST_FAULT: ;       // only rst leaves
        default:  r_state <= ST_FAULT;
      endcase
    end
  end

  assign bus.pc          = r_pc;
  assign bus.depth       = r_depth;
  assign bus.stack_full  = r_full;
  assign bus.stack_empty = r_empty;
  assign bus.fault       = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
// It applies a directed vector table, an overflow sequence, and random traffic checked against a queue-based model.
module tb_pc_sequencer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pc_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] op;
    logic [7:0] tgt;
    logic       cond;
    logic [7:0] e_pc;
    logic [2:0] e_depth;
    logic       e_full;
    logic       e_empty;
    logic       e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic e, logic [2:0] o, logic [7:0] t, logic c,
                              logic [7:0] p, logic [2:0] d, logic f, logic em, logic fl);
    vec_t v;
    v.rst = r; v.en = e; v.op = o; v.tgt = t; v.cond = c;
    v.e_pc = p; v.e_depth = d; v.e_full = f; v.e_empty = em; v.e_fault = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [2:0] o,
                       input logic [7:0] t, input logic c);
    @(negedge clk);
    rst = r; bus.en = e; bus.op = o; bus.target = t; bus.cond = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input logic [2:0] d,
                         input logic f, input logic em, input logic fl);
    chk({tag, ".pc"},    32'(bus.pc),          32'(p));
    chk({tag, ".depth"}, 32'(bus.depth),       32'(d));
    chk({tag, ".full"},  32'(bus.stack_full),  32'(f));
    chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(em));
    chk({tag, ".fault"}, 32'(bus.fault),       32'(fl));
  endtask

  // Reference model: PC value, return addresses in a queue, sticky fault
  logic [7:0] m_pc;
  logic [7:0] m_q[$];
  logic       m_fault;

  task automatic model_step(input logic r, input logic e, input logic [2:0] o,
                            input logic [7:0] t, input logic c);
    if (r) begin
      m_pc = 8'h00; m_q.delete(); m_fault = 1'b0;
    end else if (!m_fault && e) begin
      if (o == 3'd0) m_pc = m_pc + 8'd1;
      else if (o == 3'd1) m_pc = c ? m_pc + t : m_pc + 8'd1;
      else if (o == 3'd2) m_pc = c ? m_pc - t : m_pc + 8'd1;
      else if (o == 3'd3) m_pc = t;
      else if (o == 3'd4) begin
        if (m_q.size() == DEPTH) m_fault = 1'b1;
        else begin m_q.push_back(m_pc + 8'd1); m_pc = t; end
      end else if (o == 3'd5) begin
        if (m_q.size() == 0) m_fault = 1'b1;
        else m_pc = m_q.pop_back();
      end
    end
  endtask

  initial begin
    rst = 1'b1; bus.en = 1'b0; bus.op = 3'd0; bus.target = 8'h00; bus.cond = 1'b0;

    //             rst en op    tgt    c   pc     d  full empty fault
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 0, 8'h01, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 1, 8'h02, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 0, 8'h03, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'h10, 0, 8'h10, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd1, 8'h05, 1, 8'h15, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 8'h20, 1, 8'hF5, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd1, 8'h07, 0, 8'hF6, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 8'h03, 0, 8'hF7, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'hFF, 0, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'hFE, 0, 8'hFE, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd1, 8'h03, 1, 8'h01, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'h02, 0, 8'h02, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd2, 8'h05, 1, 8'hFD, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'h04, 0, 8'h04, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 8'h40, 0, 8'h40, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd4, 8'h80, 1, 8'h80, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h77, 0, 8'h41, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h05, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 3'd3, 8'h33, 0, 8'h05, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd6, 8'h33, 1, 8'h05, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd7, 8'h33, 0, 8'h05, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'hFF, 0, 8'hFF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd4, 8'h10, 0, 8'h10, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd3, 8'h22, 0, 8'h22, 0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 3'd4, 8'h50, 0, 8'h00, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 3'd5, 8'h00, 0, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3'd0, 8'h00, 0, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(0, 1, 3'd3, 8'h77, 0, 8'h00, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].tgt, vecs[i].cond);
      chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_depth,
              vecs[i].e_full, vecs[i].e_empty, vecs[i].e_fault);
    end

    // Overflow: fill the stack, then one more call faults and freezes
    apply(1, 0, 3'd0, 8'h00, 0);
    apply(0, 1, 3'd4, 8'h11, 0); chk_all("ovf_c1", 8'h11, 1, 0, 0, 0);
    apply(0, 1, 3'd4, 8'h22, 0); chk_all("ovf_c2", 8'h22, 2, 0, 0, 0);
    apply(0, 1, 3'd4, 8'h33, 0); chk_all("ovf_c3", 8'h33, 3, 0, 0, 0);
    apply(0, 1, 3'd4, 8'h44, 0); chk_all("ovf_c4", 8'h44, 4, 1, 0, 0);
    apply(0, 1, 3'd4, 8'h55, 0); chk_all("ovf_c5", 8'h44, 4, 1, 0, 1);
    apply(0, 1, 3'd0, 8'h00, 0); chk_all("ovf_next", 8'h44, 4, 1, 0, 1);
    apply(0, 1, 3'd3, 8'h99, 0); chk_all("ovf_jump", 8'h44, 4, 1, 0, 1);
    apply(0, 1, 3'd5, 8'h00, 0); chk_all("ovf_ret", 8'h44, 4, 1, 0, 1);
    apply(1, 1, 3'd4, 8'h50, 0); chk_all("ovf_rst", 8'h00, 0, 0, 1, 0);

    // Random traffic against the reference model
    model_step(1, 0, 3'd0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      logic       r, e, c;
      logic [2:0] o;
      logic [7:0] t;
      r = ($urandom_range(0, 39) == 0);
      e = ($urandom_range(0, 3) != 0);
      o = 3'($urandom_range(0, 7));
      t = 8'($urandom);
      c = 1'($urandom);
      apply(r, e, o, t, c);
      model_step(r, e, o, t, c);
      chk_all($sformatf("rnd%0d", n), m_pc, 3'(m_q.size()),
              m_q.size() == DEPTH, m_q.size() == 0, m_fault);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
